lsu_ctrl: RTL and testbench

//  Load/store unit downstream of the ALU. Takes the ALU result as the effective address and runs one

---
 rtl/lsu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: one data-memory transaction per load/store over a req/ack handshake,
// with store lane alignment and load extension. Optional misalign trap: MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        fault_o
);

    localparam int unsigned CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;

    logic [1:0]         off;
    logic               legal_d;
    logic               misalign_d;
    logic               trap_d;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;
    logic [31:0]        load_ext;

    assign off     = addr_i[1:0];
    assign stall_o = ((state_q == S_IDLE) && start_i) || (state_q == S_REQ);

    // Request decode: legality, optional misalign trap, lane enables and replicated data
    always_comb begin
        legal_d    = 1'b0;
        misalign_d = 1'b0;
        be_d       = 4'hF;
        wdata_d    = '0;
        if (is_store_i) begin
            legal_d = funct3_i inside {3'b000, 3'b001, 3'b010};
        end else begin
            legal_d = funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
`ifdef MISALIGN_TRAP_EN
        misalign_d = ((funct3_i[1:0] == 2'b01) && off[0]) ||
                     ((funct3_i[1:0] == 2'b10) && (off != 2'b00));
`else
        misalign_d = 1'b0;
`endif
        if (is_store_i) begin
            case (funct3_i[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << off;
                    wdata_d = {4{store_data_i[7:0]}};
                end
                2'b01: begin
                    be_d    = off[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{store_data_i[15:0]}};
                end
                default: begin
                    be_d    = 4'hF;
                    wdata_d = store_data_i;
                end
            endcase
        end
    end

    assign trap_d = !legal_d || misalign_d;

    // Load lane select and sign/zero extension from the latched request
    always_comb begin
        byte_sel = '0;
        half_sel = '0;
        load_ext = mem_rdata_i;
        case (off_q)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            done_o      <= 1'b0;
            fault_o     <= 1'b0;
            load_data_o <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (trap_d) begin
                            state_q     <= S_DONE;
                            done_o      <= 1'b1;
                            fault_o     <= 1'b1;
                            load_data_o <= '0;
                        end else begin
                            state_q     <= S_REQ;
                            cnt_q       <= '0;
                            funct3_q    <= funct3_i;
                            off_q       <= off;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= is_store_i;
                            mem_addr_o  <= {addr_i[31:2], 2'b00};
                            mem_be_o    <= be_d;
                            mem_wdata_o <= wdata_d;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        state_q   <= S_DONE;
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                        done_o    <= 1'b1;
                        fault_o   <= 1'b0;
                        if (!mem_we_o) begin
                            load_data_o <= load_ext;
                        end
                    end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
                        state_q     <= S_DONE;
                        mem_req_o   <= 1'b0;
                        mem_we_o    <= 1'b0;
                        done_o      <= 1'b1;
                        fault_o     <= 1'b1;
                        load_data_o <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_o  <= 1'b0;
                    fault_o <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, hand sequences for reset/ack corner
// cases, and random accesses against a behavioural reference model.
module tb_lsu_ctrl;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] load_data_o;
    logic        fault_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          ack_dly;
        logic        trap;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ldata;
    } vec_t;

    lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_be_o     (mem_be_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .load_data_o  (load_data_o),
        .fault_o      (fault_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic [31:0] rdata, input int dly,
                                input logic trap, input logic [3:0] be, input logic [31:0] wdata,
                                input logic [31:0] ldata);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.ack_dly = dly; v.trap = trap; v.be = be; v.wdata = wdata; v.ldata = ldata;
        return v;
    endfunction

    // Reference model: expected lanes and load value from the access rules, using plain arithmetic
    function automatic vec_t model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] sdata, input logic [31:0] rdata, input int dly);
        vec_t        v;
        int          off;
        int          sz;
        bit          legal;
        bit          mis;
        logic [31:0] b;
        logic [31:0] h;
        off = int'(addr[1:0]);
        sz  = int'(f3[1:0]);
        legal = st ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
`endif
        v = mk(st, f3, addr, sdata, rdata, dly, !legal || mis, 4'hF, 32'h0, 32'h0);
        if (st) begin
            if (sz == 0) begin
                v.be    = 4'(1 << off);
                v.wdata = {24'h0, sdata[7:0]} * 32'h0101_0101;
            end else if (sz == 1) begin
                v.be    = (off >= 2) ? 4'hC : 4'h3;
                v.wdata = {16'h0, sdata[15:0]} * 32'h0001_0001;
            end else begin
                v.wdata = sdata;
            end
        end
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    v.ldata = (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    v.ldata = (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    v.ldata = b;
            3'd5:    v.ldata = h;
            default: v.ldata = rdata;
        endcase
        if (v.trap) v.ldata = 32'h0;
        return v;
    endfunction

    // Drive one access from IDLE and check every cycle until back in IDLE
    task automatic run_vec(input vec_t v, input bit drop_start);
        bit tmo;
        bit flt;
        int exp_req;
        int k;
        tmo     = !v.trap && (v.ack_dly == 0 || v.ack_dly > int'(TO));
        flt     = v.trap || tmo;
        exp_req = v.trap ? 0 : (tmo ? int'(TO) : v.ack_dly);
        start_i      = 1'b1;
        is_store_i   = v.st;
        funct3_i     = v.f3;
        addr_i       = v.addr;
        store_data_i = v.sdata;
        @(negedge clk_i);
        chk("stall_idle", 32'(stall_o), 32'd1);
        chk("req_idle", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
        k = 0;
        while (mem_req_o === 1'b1 && k < int'(TO) + 2) begin
            k++;
            if (drop_start && k >= 2) start_i = 1'b0;
            mem_ack_i   = (k == v.ack_dly);
            mem_rdata_i = mem_ack_i ? v.rdata : $urandom();
            @(negedge clk_i);
            chk("req_we", 32'(mem_we_o), 32'(v.st));
            chk("req_addr", mem_addr_o, v.addr & 32'hFFFF_FFFC);
            chk("req_be", 32'(mem_be_o), 32'(v.be));
            if (v.st) chk("req_wdata", mem_wdata_o, v.wdata);
            chk("req_stall", 32'(stall_o), 32'd1);
            chk("req_done", 32'(done_o), 32'd0);
            @(posedge clk_i); #1;
            mem_ack_i = 1'b0;
        end
        chk("req_cycles", 32'(k), 32'(exp_req));
        chk("done_pulse", 32'(done_o), 32'd1);
        chk("done_fault", 32'(fault_o), 32'(flt));
        chk("done_req", 32'(mem_req_o), 32'd0);
        chk("done_stall", 32'(stall_o), 32'd0);
        if (!v.st || flt) chk("load_data", load_data_o, flt ? 32'h0 : v.ldata);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("post_done", 32'(done_o), 32'd0);
        chk("post_req", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b0;
        addr_i = '0; store_data_i = '0; mem_rdata_i = '0; mem_ack_i = 1'b0;

        tbl.push_back(mk(0, 3'b000, 32'h0000_1003, 0, 32'h80AA_BBCC, 1, 0, 4'hF, 0, 32'hFFFF_FF80));
        tbl.push_back(mk(1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 0, 1, 0, 4'hC, 32'hABCD_ABCD, 0));
        tbl.push_back(mk(0, 3'b010, 32'h0000_4000, 0, 32'hDEAD_BEEF, 3, 0, 4'hF, 0, 32'hDEAD_BEEF));
        tbl.push_back(mk(0, 3'b010, 32'h0000_4004, 0, 32'h1111_1111, 0, 0, 4'hF, 0, 0));
`ifdef MISALIGN_TRAP_EN
        tbl.push_back(mk(0, 3'b010, 32'h0000_0102, 0, 32'h1122_3344, 1, 1, 4'hF, 0, 0));
        tbl.push_back(mk(0, 3'b001, 32'h0000_0021, 0, 32'h0000_8001, 1, 1, 4'hF, 0, 0));
`else
        tbl.push_back(mk(0, 3'b010, 32'h0000_0102, 0, 32'h1122_3344, 1, 0, 4'hF, 0, 32'h1122_3344));
        tbl.push_back(mk(0, 3'b001, 32'h0000_0021, 0, 32'h0000_8001, 1, 0, 4'hF, 0, 32'hFFFF_8001));
`endif
        tbl.push_back(mk(0, 3'b011, 32'h0000_0010, 0, 0, 1, 1, 4'hF, 0, 0));
        tbl.push_back(mk(1, 3'b100, 32'h0000_0010, 32'hFF, 0, 1, 1, 4'hF, 0, 0));
        tbl.push_back(mk(0, 3'b100, 32'h0000_0010, 0, 32'h0000_00F0, 1, 0, 4'hF, 0, 32'h0000_00F0));
        tbl.push_back(mk(0, 3'b101, 32'h0000_0022, 0, 32'h8001_0000, 2, 0, 4'hF, 0, 32'h0000_8001));
        tbl.push_back(mk(0, 3'b001, 32'h0000_0022, 0, 32'h8001_0000, 1, 0, 4'hF, 0, 32'hFFFF_8001));
        tbl.push_back(mk(0, 3'b000, 32'h0000_1001, 0, 32'h0000_7F00, 1, 0, 4'hF, 0, 32'h0000_007F));
        tbl.push_back(mk(1, 3'b000, 32'h0000_0031, 32'h0000_0055, 0, 1, 0, 4'b0010, 32'h5555_5555, 0));
        tbl.push_back(mk(1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 0, 2, 0, 4'hF, 32'hCAFE_F00D, 0));
        tbl.push_back(mk(0, 3'b010, 32'h0000_0060, 0, 32'h0102_0304, 4, 0, 4'hF, 0, 32'h0102_0304));
        tbl.push_back(mk(0, 3'b010, 32'h0000_0064, 0, 32'h0000_0055, 5, 0, 4'hF, 0, 0));
        tbl.push_back(mk(1, 3'b000, 32'h0000_0033, 32'h0000_00A5, 0, 0, 0, 4'b1000, 32'hA5A5_A5A5, 0));

        // Reset values
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_be", 32'(mem_be_o), 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'h0);
        chk("rst_ldata", load_data_o, 32'h0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);

        // Ack while idle is ignored
        @(posedge clk_i); #1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("idle_ack_done", 32'(done_o), 32'd0);
        chk("idle_ack_ldata", load_data_o, 32'h0);
        chk("idle_ack_req", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;

        foreach (tbl[i]) run_vec(tbl[i], 1'b0);

        // start_i dropping mid-access does not abort it
        run_vec(mk(0, 3'b010, 32'h0000_0008, 0, 32'h0BAD_F00D, 3, 0, 4'hF, 0, 32'h0BAD_F00D), 1'b1);

        // Reset during REQ, then a late ack
        start_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h50;
        @(posedge clk_i); #1;
        chk("mid_rst_req_on", 32'(mem_req_o), 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b0; start_i = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        @(negedge clk_i);
        chk("mid_rst_req", 32'(mem_req_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("late_ack_done", 32'(done_o), 32'd0);
        chk("late_ack_req", 32'(mem_req_o), 32'd0);
        chk("late_ack_ldata", load_data_o, 32'h0);
        @(posedge clk_i); #1;

        // Random accesses against the reference model
        for (int n = 0; n < 300; n++) begin
            rv = model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                       $urandom(), $urandom(), int'($urandom_range(0, 6)));
            run_vec(rv, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
